// File: rtl/genie_conv_sched.sv
// Round-robin scheduler sharing one combinational converter among N_REQ requesters.
// Optional packet locking is compiled in when GENIE_CONV_SCHED_LOCK_EN is defined.
module genie_conv_sched #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*WIDTH_IN-1:0] i_req_data,
  input  logic [N_REQ-1:0]          i_req_eop,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [WIDTH_IN-1:0]       o_conv_in,
  output logic                      o_conv_valid,
  input  logic [WIDTH_OUT-1:0]      i_conv_out,
  output logic                      o_rsp_valid,
  output logic [WIDTH_OUT-1:0]      o_rsp_data,
  output logic [ID_W-1:0]           o_rsp_id,
  input  logic                      i_rsp_ready
);

  logic                slot_free_s;
  logic                found_s;
  logic                grant_s;
  logic [ID_W-1:0]     winner_s;
  logic [ID_W-1:0]     idx_s;
  logic [ID_W-1:0]     last_grant_r;
  logic [N_REQ-1:0]    elig_s;
  logic [WIDTH_IN-1:0] data_arr_s [N_REQ];
  int                  idx_v;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr_s[g] = i_req_data[g*WIDTH_IN +: WIDTH_IN];
  end

  // A held response that is being consumed this cycle frees the slot.
  assign slot_free_s = !o_rsp_valid || i_rsp_ready;

`ifdef GENIE_CONV_SCHED_LOCK_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t     state_r;
  lock_state_t     state_next_s;
  logic [ID_W-1:0] owner_r;
  logic [ID_W-1:0] owner_next_s;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= UNLOCKED;
      owner_r <= '0;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
    end
  end

  // Lock next state: a beat without eop keeps the bus for its owner.
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    if (grant_s) begin
      owner_next_s = winner_s;
      if (i_req_eop[winner_s]) begin
        state_next_s = UNLOCKED;
      end else begin
        state_next_s = LOCKED;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // Eligibility mask: only the owner may compete while locked.
  always_comb begin
    elig_s = i_req_valid;
    case (state_r)
      UNLOCKED: elig_s = i_req_valid;
      LOCKED: begin
        for (int k = 0; k < N_REQ; k++) begin
          elig_s[k] = i_req_valid[k] && (ID_W'(k) == owner_r);
        end
      end
      default: elig_s = '0;
    endcase
  end
`else
  logic unused_eop_s;

  assign elig_s       = i_req_valid;
  assign unused_eop_s = ^i_req_eop;
`endif

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    idx_v    = 0;
    idx_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_v = (int'(last_grant_r) + 1 + i) % N_REQ;
      idx_s = idx_v[ID_W-1:0];
      if (!found_s && elig_s[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_s = found_s && slot_free_s && reset;

  // Combinational accept strobes and converter drive for the winner.
  always_comb begin
    o_req_ready  = '0;
    o_conv_valid = 1'b0;
    o_conv_in    = '0;
    if (grant_s) begin
      o_req_ready[winner_s] = 1'b1;
      o_conv_valid          = 1'b1;
      o_conv_in             = data_arr_s[winner_s];
    end else begin
      o_conv_valid = 1'b0;
    end
  end

  // Response slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_id     <= '0;
      last_grant_r <= ID_W'(N_REQ - 1);
    end else if (grant_s) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_data   <= i_conv_out;
      o_rsp_id     <= winner_s;
      last_grant_r <= winner_s;
    end else if (i_rsp_ready) begin
      o_rsp_valid  <= 1'b0;
    end else begin
      o_rsp_valid  <= o_rsp_valid;
    end
  end

endmodule

// File: tb/tb_genie_conv_sched.sv
// Directed table-driven bench for genie_conv_sched (N_REQ=4, 8-bit fields).
// Converter model: out = in ^ 8'h3B (maps 8'h07 to 8'h3C).
module tb_genie_conv_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_eop;
  logic [3:0]  o_req_ready;
  logic [7:0]  o_conv_in;
  logic        o_conv_valid;
  logic [7:0]  i_conv_out;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic [1:0]  o_rsp_id;
  logic        i_rsp_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  eop;
    logic        rr;
    logic [3:0]  ex_ready;
    logic        ex_cv;
    logic [7:0]  ex_cin;
    logic        ex_rv;
    logic [7:0]  ex_rd;
    logic [1:0]  ex_rid;
  } vec_t;

  localparam logic [31:0] D = 32'h40302010;

  vec_t tbl [13];
  vec_t v;

  always #5 clk = ~clk;

  assign i_conv_out = o_conv_in ^ 8'h3B;

  genie_conv_sched #(.N_REQ(4), .WIDTH_IN(8), .WIDTH_OUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_data   (i_req_data),
    .i_req_eop    (i_req_eop),
    .o_req_ready  (o_req_ready),
    .o_conv_in    (o_conv_in),
    .o_conv_valid (o_conv_valid),
    .i_conv_out   (i_conv_out),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_id     (o_rsp_id),
    .i_rsp_ready  (i_rsp_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic rst_v, input vec_t s);
    @(negedge clk);
    reset       = rst_v;
    i_req_valid = s.valid;
    i_req_data  = s.data;
    i_req_eop   = s.eop;
    i_rsp_ready = s.rr;
    #1;
    chk({name, " ready"},   32'(o_req_ready),  32'(s.ex_ready));
    chk({name, " cvalid"},  32'(o_conv_valid), 32'(s.ex_cv));
    chk({name, " conv_in"}, 32'(o_conv_in),    32'(s.ex_cin));
    @(posedge clk);
    #1;
    chk({name, " rsp_valid"}, 32'(o_rsp_valid), 32'(s.ex_rv));
    if (s.ex_rv) begin
      chk({name, " rsp_data"}, 32'(o_rsp_data), 32'(s.ex_rd));
      chk({name, " rsp_id"},   32'(o_rsp_id),   32'(s.ex_rid));
    end
  endtask

  initial begin
    reset       = 1'b0;
    i_req_valid = 4'b0000;
    i_req_data  = 32'h0;
    i_req_eop   = 4'b0000;
    i_rsp_ready = 1'b1;

    //           valid    data                eop      rr    ready    cv    cin    rv    rd     rid
    tbl[0]  = '{4'b1111, D,                  4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 8'h2B, 2'd0};
    tbl[1]  = '{4'b1111, D,                  4'b1111, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    tbl[2]  = '{4'b1111, D,                  4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    tbl[3]  = '{4'b1111, D,                  4'b1111, 1'b1, 4'b1000, 1'b1, 8'h40, 1'b1, 8'h7B, 2'd3};
    tbl[4]  = '{4'b1111, D,                  4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 8'h2B, 2'd0};
    tbl[5]  = '{4'b0000, D,                  4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    tbl[6]  = '{4'b1000, 32'h07302010,       4'b1111, 1'b1, 4'b1000, 1'b1, 8'h07, 1'b1, 8'h3C, 2'd3};
    tbl[7]  = '{4'b0110, D,                  4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 8'h3C, 2'd3};
    tbl[8]  = '{4'b0110, D,                  4'b1111, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    tbl[9]  = '{4'b0101, D,                  4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    tbl[10] = '{4'b0011, D,                  4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b1, 8'h2B, 2'd0};
    tbl[11] = '{4'b0000, D,                  4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 8'h2B, 2'd0};
    tbl[12] = '{4'b0000, D,                  4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};

    // Reset with requests pending: nothing granted, slot empty.
    v = '{4'b1111, D, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    step("rst0", 1'b0, v);
    step("rst1", 1'b0, v);
    chk("rst rsp_data", 32'(o_rsp_data), 32'h0);
    chk("rst rsp_id",   32'(o_rsp_id),   32'h0);

    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), 1'b1, tbl[i]);
    end

    // Backpressure: response id 2 data A5 held for three cycles.
    v = '{4'b0100, 32'h409E2010, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h9E, 1'b1, 8'hA5, 2'd2};
    step("stall_acc", 1'b1, v);
    v = '{4'b1111, D, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b1, 8'hA5, 2'd2};
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), 1'b1, v);
    end
    v = '{4'b0000, D, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    step("stall_drain", 1'b1, v);

`ifdef GENIE_CONV_SCHED_LOCK_EN
    // Requester 1 locks for three beats; requester 2 waits, even while 1 idles.
    v = '{4'b0110, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    step("lock_b0", 1'b1, v);
    v = '{4'b0100, D, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    step("lock_hold", 1'b1, v);
    v = '{4'b0110, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    step("lock_b1", 1'b1, v);
    v = '{4'b0110, D, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    step("lock_b2", 1'b1, v);
    v = '{4'b0110, D, 4'b0010, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    step("lock_r2", 1'b1, v);
`else
    // Without locking, eop is ignored and 1 and 2 alternate.
    v = '{4'b0110, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    step("alt0", 1'b1, v);
    v = '{4'b0110, D, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    step("alt1", 1'b1, v);
    v = '{4'b0110, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h20, 1'b1, 8'h1B, 2'd1};
    step("alt2", 1'b1, v);
    v = '{4'b0110, D, 4'b0010, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    step("alt3", 1'b1, v);
`endif

    // Reset while a response is held, then priority restarts at index 0.
    v = '{4'b1111, D, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    step("mid_rst", 1'b0, v);
    chk("mid_rst rsp_data", 32'(o_rsp_data), 32'h0);
    v = '{4'b1100, D, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h30, 1'b1, 8'h0B, 2'd2};
    step("post_rst", 1'b1, v);
    v = '{4'b0000, D, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0};
    step("idle", 1'b1, v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
